// File: rtl/apb_master_arbiter.sv
// apb_master_arbiter: round-robin two-requester sequencer onto one APB port.
// Define APB_TIMEOUT_EN to abort ACCESS after TIMEOUT_CYCLES of PREADY low.
module apb_master_arbiter #(
  parameter int ADDRWIDTH      = 32,
  parameter int CLK_RATIO      = 2,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                 HCLK,
  input  logic                 HRESET,
  input  logic                 req0_valid,
  input  logic [ADDRWIDTH-1:0] req0_addr,
  input  logic                 req0_write,
  input  logic [31:0]          req0_wdata,
  output logic                 done0,
  output logic [31:0]          rdata0,
  output logic                 err0,
  input  logic                 req1_valid,
  input  logic [ADDRWIDTH-1:0] req1_addr,
  input  logic                 req1_write,
  input  logic [31:0]          req1_wdata,
  output logic                 done1,
  output logic [31:0]          rdata1,
  output logic                 err1,
  output logic [ADDRWIDTH-1:0] PADDR,
  output logic                 PSEL,
  output logic                 PENABLE,
  output logic                 PWRITE,
  output logic [31:0]          PWDATA,
  input  logic [31:0]          PRDATA,
  input  logic                 PREADY,
  input  logic                 PSLVERR
);

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS,
    DONE
  } state_t;

  localparam logic [2:0] RELOAD = 3'(CLK_RATIO - 1);

  state_t     state;
  logic [2:0] pcnt;
  logic       pclken;
  logic       last_grant;
  logic       gnt;
  logic       win;
  logic       tmo;

  assign pclken = (pcnt == 3'd0);

  // both valid: the one not served last; otherwise whoever is valid
  assign win = (req0_valid && req1_valid) ? ~last_grant : req1_valid;

  always_ff @(posedge HCLK) begin
    if (HRESET) pcnt <= 3'd0;
    else if (pclken) pcnt <= RELOAD;
    else pcnt <= pcnt - 3'd1;
  end

`ifdef APB_TIMEOUT_EN
  logic [15:0] tcnt;

  assign tmo = !PREADY &&
               (tcnt == 16'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge HCLK) begin
    if (HRESET) tcnt <= '0;
    else if (state != ACCESS) tcnt <= '0;
    else if (!PREADY) tcnt <= tcnt + 16'd1;
  end
`else
  assign tmo = 1'b0;
`endif

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      gnt        <= 1'b0;
      PADDR      <= '0;
      PSEL       <= 1'b0;
      PENABLE    <= 1'b0;
      PWRITE     <= 1'b0;
      PWDATA     <= '0;
      done0      <= 1'b0;
      done1      <= 1'b0;
      rdata0     <= '0;
      rdata1     <= '0;
      err0       <= 1'b0;
      err1       <= 1'b0;
    end else begin
      done0  <= 1'b0;
      done1  <= 1'b0;
      rdata0 <= '0;
      rdata1 <= '0;
      err0   <= 1'b0;
      err1   <= 1'b0;
      unique case (state)
        IDLE: begin
          if (pclken && (req0_valid || req1_valid)) begin
            gnt        <= win;
            last_grant <= win;
            PSEL       <= 1'b1;
            state      <= SETUP;
            if (win) begin
              PADDR  <= {req1_addr[ADDRWIDTH-1:2], 2'b00};
              PWRITE <= req1_write;
              PWDATA <= req1_wdata;
            end else begin
              PADDR  <= {req0_addr[ADDRWIDTH-1:2], 2'b00};
              PWRITE <= req0_write;
              PWDATA <= req0_wdata;
            end
          end
        end
        SETUP: begin
          if (pclken) begin
            PENABLE <= 1'b1;
            state   <= ACCESS;
          end
        end
        ACCESS: begin
          if (pclken && PREADY) begin
            PSEL    <= 1'b0;
            PENABLE <= 1'b0;
            state   <= DONE;
            done0   <= ~gnt;
            done1   <= gnt;
            err0    <= ~gnt & PSLVERR;
            err1    <= gnt & PSLVERR;
            rdata0  <= (!gnt && !PWRITE) ? PRDATA : '0;
            rdata1  <= (gnt && !PWRITE) ? PRDATA : '0;
          end else if (tmo) begin
            PSEL    <= 1'b0;
            PENABLE <= 1'b0;
            state   <= DONE;
            done0   <= ~gnt;
            done1   <= gnt;
            err0    <= ~gnt;
            err1    <= gnt;
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/apb_master_arbiter.md
Name: apb_master_arbiter

Overview:
- Two-requester arbiter and sequencer in front of a single APB master port, sitting in the peripheral subsystem next to the AHB-to-APB bridge.
- Lets two on-chip initiators share one APB segment, for example the CPU-side command port and a DMA/debug port.
- Each initiator uses a simple valid/done command interface. The block grants round-robin, runs an APB SETUP/ACCESS sequence paced by an internal PCLKEN divider, and returns read data and error per requester.

Parameters:
- ADDRWIDTH, 32, width of request address and PADDR; PADDR[1:0] is forced to 0.
- CLK_RATIO, 2, HCLK cycles per PCLK period; legal range 1..8; 1 means PCLKEN is constantly high.
- TIMEOUT_CYCLES, 255, HCLK cycles of PREADY low in ACCESS before abort; legal range 1..65535; used only with APB_TIMEOUT_EN.

Ports:
- HCLK  in  1  clock
- HRESET  in  1  synchronous, active-high reset
- req0_valid  in  1  requester 0 command valid; held until done0
- req0_addr  in  ADDRWIDTH  requester 0 byte address
- req0_write  in  1  1 = write, 0 = read
- req0_wdata  in  32  requester 0 write data
- done0  out  1  one-cycle completion pulse for requester 0
- rdata0  out  32  read data, valid while done0 = 1
- err0  out  1  PSLVERR or timeout, valid while done0 = 1
- req1_valid, req1_addr, req1_write, req1_wdata, done1, rdata1, err1  as above, for requester 1
- PADDR  out  ADDRWIDTH  APB address
- PSEL  out  1  APB select
- PENABLE  out  1  APB enable
- PWRITE  out  1  APB direction
- PWDATA  out  32  APB write data
- PRDATA  in  32  APB read data
- PREADY  in  1  APB ready
- PSLVERR  in  1  APB error

Behaviour:
- Clocking and reset:
  - Single clock HCLK. Reset is synchronous and active-high on HRESET.
  - Reset values: all outputs 0; state IDLE; PCLKEN counter 0; last_grant = 1, so requester 0 wins the first tie.
- PCLKEN divider:
  - 3-bit down-counter; reloads CLK_RATIO-1 when it reaches 0.
  - PCLKEN = (counter == 0).
- State machine, registered, 4 states:
  - IDLE: if PCLKEN and any req_valid, choose the winner and latch addr (low 2 bits cleared), write and wdata into internal registers. Go to SETUP. Otherwise stay in IDLE.
  - SETUP: PSEL = 1, PENABLE = 0. If PCLKEN, go to ACCESS.
  - ACCESS: PSEL = 1, PENABLE = 1. If PCLKEN and PREADY, capture PRDATA (reads only; writes capture 0) and PSLVERR, then go to DONE. Otherwise stay in ACCESS.
  - DONE: assert done of the granted requester for exactly one cycle, with rdata and err held. Go to IDLE unconditionally.
- Arbitration:
  - Round-robin. When both requesters are valid, grant the one that is not last_grant.
  - When only one is valid, grant it.
  - last_grant updates on every grant.
  - Fairness bound: a continuously valid requester waits at most one transfer of the other requester.
- Outputs:
  - PADDR, PWRITE and PWDATA come from the latched registers and are stable from SETUP through ACCESS.
  - In IDLE and DONE, PADDR, PWRITE and PWDATA hold their last values; PSEL = PENABLE = 0.
  - rdataN and errN are 0 whenever doneN = 0.
- Latency, CLK_RATIO = 1, zero APB wait:
  - req_valid seen in IDLE at cycle 0, SETUP at cycle 1, ACCESS at cycle 2, done at cycle 3.
  - Each extra PREADY-low PCLK period adds CLK_RATIO cycles.
- Handshake:
  - The requester holds valid and its command fields stable until it sees done.
  - It drops valid, or presents the next command, from the cycle after done. IDLE resamples in that cycle.
- Boundary cases:
  - A requester that deasserts valid after the grant has no effect: the transfer completes and done still pulses.
  - A non-granted requester's inputs are ignored until it is granted.
  - done0 and done1 are never high together.
  - HRESET asserted in any state: the next edge returns to IDLE with all outputs 0; a cut-off transfer is dropped and gets no done.
  - A requester asserting valid during its own DONE cycle is treated as a new command in IDLE.

Optional Feature:
- Macro: APB_TIMEOUT_EN.
- When defined:
  - A 16-bit counter clears on entry to ACCESS and increments each HCLK cycle in ACCESS while PREADY is low.
  - When it reaches TIMEOUT_CYCLES, go to DONE with err = 1 and rdata = 0; PSEL/PENABLE drop in DONE.
  - A PREADY that arrives in the same cycle as the timeout wins: normal completion.
- When undefined: no counter exists, and ACCESS waits indefinitely for PREADY.

Test Plan:
- CLK_RATIO = 1, PREADY = 1; req0 read at 0x4000_0006 -> PADDR = 0x4000_0004; PSEL high cycles 1-2, PENABLE cycle 2; done0 at cycle 3 with rdata0 = PRDATA = 0xA5A5_1234, err0 = 0.
- Both requesters valid continuously, 4 writes each -> grants alternate 0,1,0,1...; no done overlap; PWDATA matches the granted requester's wdata.
- CLK_RATIO = 4; req1 write, PREADY low for 2 PCLK periods -> SETUP lasts 4 cycles, ACCESS lasts 12 cycles, then done1 with err1 = 0.
- PSLVERR = 1 with PREADY on a req0 read -> done0 with err0 = 1 and rdata0 = PRDATA.
- HRESET pulsed while in ACCESS -> next cycle PSEL = PENABLE = 0, no done; a fresh req0 after reset is granted first.
- APB_TIMEOUT_EN, TIMEOUT_CYCLES = 10, PREADY stuck low -> done with err = 1 and rdata = 0 after 10 ACCESS cycles; without the macro, no done within 1000 cycles.
